// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared widths, FSM state and bit-phase encodings, and state
//            classification helpers for the I2C memory master.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

   localparam int ADDR_W = 7;
   localparam int MEM_AW = 5;
   localparam int DATA_W = 8;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      START  = 4'd1,
      ADDR   = 4'd2,
      ACK_A  = 4'd3,
      MADDR  = 4'd4,
      ACK_M  = 4'd5,
      WDATA  = 4'd6,
      ACK_W  = 4'd7,
      RSTART = 4'd8,
      RADDR  = 4'd9,
      ACK_R  = 4'd10,
      RDATA  = 4'd11,
      MNACK  = 4'd12,
      STOP   = 4'd13
   } state_t;

   // Quarter-bit phases: P0 SCL low, P1/P2 SCL high, P3 SCL low
   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2,
      PH3 = 2'd3
   } phase_t;

   // States that last eight bit periods (bit counter active)
   function automatic logic is_byte_state(input state_t s);
      return (s == ADDR) || (s == MADDR) || (s == WDATA) || (s == RADDR) || (s == RDATA);
   endfunction

   // Slave acknowledge slots, where a sampled 1 aborts to STOP
   function automatic logic is_ack_state(input state_t s);
      return (s == ACK_A) || (s == ACK_M) || (s == ACK_W) || (s == ACK_R);
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_mem_master_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_mem_master_if
// Brief    : Request/response bundle between a requester and the I2C memory
//            master. The master modport is the requester, the slave modport
//            is the controller that serves the request.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_mem_master_if;
   import i2c_pkg::*;

   logic              en;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] data_wr;
   logic [DATA_W-1:0] data_rd;
   logic              ack_err;
   logic              busy;

   modport master (
      output en, rw, addr, mem_addr, data_wr,
      input  data_rd, ack_err, busy
   );

   modport slave (
      input  en, rw, addr, mem_addr, data_wr,
      output data_rd, ack_err, busy
   );

endinterface
`default_nettype wire

// File: rtl/i2c_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bit_timer
// Brief    : Divides clk into quarter-bit phases of DIV cycles each and flags
//            the last cycle of every phase and of every bit.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bit_timer
   import i2c_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   run,
   output phase_t phase,
   output logic   phase_end,
   output logic   bit_end
);

   localparam int               CNT_W     = $clog2(DIV);
   localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_phase;
   logic             w_phase_end;

   assign w_phase_end = run && (r_cnt == C_CNT_MAX);

   // Clock count within a phase and phase index within a bit; parked at zero while idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_phase <= 2'd0;
      end else if (!run) begin
         r_cnt   <= '0;
         r_phase <= 2'd0;
      end else if (w_phase_end) begin
         r_cnt   <= '0;
         r_phase <= r_phase + 2'd1;
      end else begin
         r_cnt   <= r_cnt + C_CNT_ONE;
      end
   end

   assign phase     = phase_t'(r_phase);
   assign phase_end = w_phase_end;
   assign bit_end   = w_phase_end && (r_phase == 2'd3);

endmodule
`default_nettype wire

// File: rtl/i2c_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : i2c_mem_master
// Brief    : Single-master I2C controller performing one byte write or one
//            byte read at a 5-bit memory address of a 7-bit-addressed slave.
//            SDA/SCL are open-drain: driven low or released.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_mem_master
   import i2c_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic                clk,
   input  logic                rst,
   i2c_mem_master_if.slave     req,
   inout  wire                 sda,
   inout  wire                 scl
);

   state_t            r_state;
   state_t            w_next;
   logic              r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic [MEM_AW-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_data_wr;
   logic [DATA_W-1:0] r_rx;
   logic [DATA_W-1:0] r_data_rd;
   logic [2:0]        r_bit;
   logic              r_nack;
   logic              r_ack_err;
   logic [1:0]        r_sda_sync;

   phase_t            w_phase;
   logic              w_phase_end;
   logic              w_bit_end;
   logic              w_sample;
   logic              w_run;
   logic              w_clk_low;
   logic [DATA_W-1:0] w_tx_byte;
   logic              w_sda_low;
   logic              w_scl_low;

   assign w_run = (r_state != IDLE);

   i2c_bit_timer #(
      .DIV       (DIV)
   ) u_bit_timer (
      .clk       (clk),
      .rst       (rst),
      .run       (w_run),
      .phase     (w_phase),
      .phase_end (w_phase_end),
      .bit_end   (w_bit_end)
   );

   // SDA is read at the end of the second SCL-high phase, when it is settled
   assign w_sample = w_phase_end && (w_phase == PH2);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // Next state: accept in IDLE, otherwise advance only on bit boundaries
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE) begin
         if (req.en) w_next = START;
      end else if (w_bit_end) begin
         case (r_state)
            START:   w_next = ADDR;
            ADDR:    if (r_bit == 3'd0) w_next = ACK_A;
            ACK_A:   w_next = r_nack ? STOP : MADDR;
            MADDR:   if (r_bit == 3'd0) w_next = ACK_M;
            ACK_M:   w_next = r_nack ? STOP : (r_rw ? WDATA : RSTART);
            WDATA:   if (r_bit == 3'd0) w_next = ACK_W;
            ACK_W:   w_next = STOP;
            RSTART:  w_next = RADDR;
            RADDR:   if (r_bit == 3'd0) w_next = ACK_R;
            ACK_R:   w_next = r_nack ? STOP : RDATA;
            RDATA:   if (r_bit == 3'd0) w_next = MNACK;
            MNACK:   w_next = STOP;
            STOP:    w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   // Line levels: standard data bits pulse SCL high in P1/P2; START,
   // RSTART and STOP move SDA while SCL is high
   always_comb begin
      w_clk_low = (w_phase == PH0) || (w_phase == PH3);
      w_tx_byte = '0;
      w_sda_low = 1'b0;
      w_scl_low = 1'b0;
      case (r_state)
         ADDR:  w_tx_byte = {r_addr, 1'b0};
         MADDR: w_tx_byte = {{(DATA_W-MEM_AW){1'b0}}, r_mem_addr};
         WDATA: w_tx_byte = r_data_wr;
         RADDR: w_tx_byte = {r_addr, 1'b1};
         default: w_tx_byte = '0;
      endcase
      case (r_state)
         IDLE: begin
            w_sda_low = 1'b0;
            w_scl_low = 1'b0;
         end
         START: begin
            w_sda_low = (w_phase == PH2) || (w_phase == PH3);
            w_scl_low = (w_phase == PH3);
         end
         RSTART: begin
            w_sda_low = (w_phase == PH2) || (w_phase == PH3);
            w_scl_low = w_clk_low;
         end
         STOP: begin
            w_sda_low = (w_phase == PH0) || (w_phase == PH1);
            w_scl_low = (w_phase == PH0);
         end
         ADDR, MADDR, WDATA, RADDR: begin
            w_sda_low = ~w_tx_byte[r_bit];
            w_scl_low = w_clk_low;
         end
         default: begin
            w_sda_low = 1'b0;
            w_scl_low = w_clk_low;
         end
      endcase
   end

   // Request latch, bit counter, SDA sampling, ack error and read data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rw       <= 1'b0;
         r_addr     <= '0;
         r_mem_addr <= '0;
         r_data_wr  <= '0;
         r_rx       <= '0;
         r_data_rd  <= '0;
         r_bit      <= 3'd7;
         r_nack     <= 1'b0;
         r_ack_err  <= 1'b0;
         r_sda_sync <= 2'b11;
      end else begin
         r_sda_sync <= {r_sda_sync[0], sda};
         if ((r_state == IDLE) && req.en) begin
            r_rw       <= req.rw;
            r_addr     <= req.addr;
            r_mem_addr <= req.mem_addr;
            r_data_wr  <= req.data_wr;
            r_ack_err  <= 1'b0;
         end
         if (w_sample) begin
            r_nack <= r_sda_sync[1];
            if (r_state == RDATA) r_rx <= {r_rx[DATA_W-2:0], r_sda_sync[1]};
         end
         if (w_bit_end) begin
            // Wraps 0 -> 7 at the end of each byte, ready for the next one
            if (is_byte_state(r_state)) r_bit <= r_bit - 3'd1;
            if (is_ack_state(r_state) && r_nack) r_ack_err <= 1'b1;
            if (r_state == MNACK) r_data_rd <= r_rx;
         end
      end
   end

   assign sda         = w_sda_low ? 1'b0 : 1'bz;
   assign scl         = w_scl_low ? 1'b0 : 1'bz;
   assign req.busy    = (r_state != IDLE);
   assign req.ack_err = r_ack_err;
   assign req.data_rd = r_data_rd;

endmodule
`default_nettype wire

// File: tb/tb_i2c_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_mem_master
// Brief    : Self-checking bench: behavioural memory slave on the bus, a
//            reference memory image, and a bus monitor for START/STOP and
//            SCL period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_mem_master;

   localparam int         DIV      = 4;
   localparam int         BIT_CLKS = 4 * DIV;
   localparam logic [6:0] SLV_ADDR = 7'd1;
   localparam int         TIMEOUT  = 4000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   wire  sda;
   wire  scl;

   pullup (sda);
   pullup (scl);

   i2c_mem_master_if req ();

   i2c_mem_master #(
      .DIV (DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .req (req),
      .sda (sda),
      .scl (scl)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural memory slave ----------------
   logic [7:0] smem [32] = '{default: 8'h00};
   logic [1:0] s_scl_q   = 2'b11;
   logic [1:0] s_sda_q   = 2'b11;
   logic       s_scl_p   = 1'b1;
   logic       s_sda_p   = 1'b1;
   logic       sl_drive  = 1'b0;
   logic       sl_ack    = 1'b0;
   logic       sl_rd     = 1'b0;
   int         sl_mode   = 0;
   int         sl_cnt    = 0;
   int         sl_byte   = 0;
   logic [7:0] sl_sh     = 8'h00;
   logic [7:0] sl_tx     = 8'h00;
   logic [4:0] sl_ptr    = 5'd0;
   logic       s_scl;
   logic       s_sda;

   assign s_scl = s_scl_q[1];
   assign s_sda = s_sda_q[1];
   assign sda   = sl_drive ? 1'b0 : 1'bz;

   always @(posedge clk) begin
      s_scl_q <= {s_scl_q[0], scl};
      s_sda_q <= {s_sda_q[0], sda};
      s_scl_p <= s_scl;
      s_sda_p <= s_sda;
      if (s_scl && s_scl_p && s_sda_p && !s_sda) begin
         sl_mode <= 1; sl_cnt <= 0; sl_byte <= 0;
         sl_ack <= 1'b0; sl_drive <= 1'b0; sl_rd <= 1'b0;
      end else if (s_scl && s_scl_p && !s_sda_p && s_sda) begin
         sl_mode <= 0; sl_ack <= 1'b0; sl_drive <= 1'b0;
      end else if (s_scl && !s_scl_p) begin
         if (sl_mode == 1 && sl_cnt < 8) begin
            sl_sh  <= {sl_sh[6:0], s_sda};
            sl_cnt <= sl_cnt + 1;
         end
      end else if (!s_scl && s_scl_p) begin
         if (sl_mode == 1) begin
            if (sl_ack) begin
               sl_ack <= 1'b0; sl_drive <= 1'b0; sl_cnt <= 0;
               if (sl_rd) begin
                  sl_mode  <= 2;
                  sl_tx    <= smem[sl_ptr];
                  sl_drive <= ~smem[sl_ptr][7];
               end
            end else if (sl_cnt == 8) begin
               if (sl_byte == 0) begin
                  if (sl_sh[7:1] == SLV_ADDR) begin
                     sl_ack <= 1'b1; sl_drive <= 1'b1; sl_rd <= sl_sh[0]; sl_byte <= 1;
                  end else begin
                     sl_mode <= 0;
                  end
               end else if (sl_byte == 1) begin
                  sl_ptr <= sl_sh[4:0]; sl_ack <= 1'b1; sl_drive <= 1'b1; sl_byte <= 2;
               end else begin
                  smem[sl_ptr] <= sl_sh; sl_ack <= 1'b1; sl_drive <= 1'b1; sl_byte <= 3;
               end
            end
         end else if (sl_mode == 2) begin
            if (sl_cnt < 7) begin
               sl_drive <= ~sl_tx[6 - sl_cnt];
               sl_cnt   <= sl_cnt + 1;
            end else if (sl_cnt == 7) begin
               sl_drive <= 1'b0;
               sl_cnt   <= 8;
            end else begin
               sl_mode <= 0;
            end
         end
      end
   end

   // ---------------- bus monitor (per transaction) ----------------
   logic m_scl_p  = 1'b1;
   logic m_sda_p  = 1'b1;
   logic m_busy_p = 1'b0;
   logic m_have   = 1'b0;
   int   cyc      = 0;
   int   m_last   = 0;
   int   m_starts = 0;
   int   m_stops  = 0;
   int   m_min    = 32'h7fffffff;
   int   m_max    = 0;

   always @(negedge clk) begin
      cyc      <= cyc + 1;
      m_scl_p  <= scl;
      m_sda_p  <= sda;
      m_busy_p <= req.busy;
      if (req.busy && !m_busy_p) begin
         m_starts <= 0; m_stops <= 0; m_have <= 1'b0;
         m_min <= 32'h7fffffff; m_max <= 0;
      end else begin
         if (scl && m_scl_p && (sda != m_sda_p)) begin
            if (!sda) m_starts <= m_starts + 1;
            else      m_stops  <= m_stops + 1;
         end
         if (scl && !m_scl_p) begin
            if (m_have) begin
               if (cyc - m_last < m_min) m_min <= cyc - m_last;
               if (cyc - m_last > m_max) m_max <= cyc - m_last;
            end
            m_last <= cyc;
            m_have <= 1'b1;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [32] = '{default: 8'h00};
   logic [7:0] ref_rd = 8'h00;

   task automatic wait_idle();
      int n;
      n = 0;
      while (req.busy && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", req.busy, 1'b0);
   endtask

   task automatic do_txn(input logic [6:0] a, input logic w, input logic [4:0] ma,
                         input logic [7:0] d);
      logic match;
      match = (a == SLV_ADDR);
      @(negedge clk);
      req.addr = a; req.rw = w; req.mem_addr = ma; req.data_wr = d; req.en = 1'b1;
      @(negedge clk);
      chk("busy_on_accept", req.busy, 1'b1);
      chk("ack_err_cleared", req.ack_err, 1'b0);
      req.en = 1'b0;
      req.addr = 7'($urandom); req.rw = 1'($urandom);
      req.mem_addr = 5'($urandom); req.data_wr = 8'($urandom);
      wait_idle();
      if (match && w)  ref_mem[ma] = d;
      if (match && !w) ref_rd = ref_mem[ma];
      chk("ack_err", req.ack_err, !match);
      chk("data_rd", req.data_rd, ref_rd);
      chk("slave_mem", smem[ma], ref_mem[ma]);
      chk("start_count", m_starts, (match && !w) ? 2 : 1);
      chk("stop_count", m_stops, 1);
      chk("scl_period_min", m_min, BIT_CLKS);
      chk("scl_period_max", m_max, BIT_CLKS);
      chk("sda_released", sda, 1'b1);
      chk("scl_released", scl, 1'b1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      req.en = 1'b0; req.rw = 1'b0; req.addr = '0; req.mem_addr = '0; req.data_wr = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", req.busy, 1'b0);
      chk("rst_ack_err", req.ack_err, 1'b0);
      chk("rst_data_rd", req.data_rd, 8'h00);
      chk("rst_sda", sda, 1'b1);
      chk("rst_scl", scl, 1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Wrong slave address: NACK on address byte
      do_txn(7'd2, 1'b1, 5'd5, 8'hA5);
      // Single write
      do_txn(SLV_ADDR, 1'b1, 5'd1, 8'h11);

      // Back-to-back writes with en held high
      @(negedge clk);
      req.rw = 1'b1; req.addr = SLV_ADDR; req.mem_addr = 5'd2; req.data_wr = 8'h22; req.en = 1'b1;
      for (int k = 2; k <= 8; k++) begin
         n = 0;
         while (!req.busy && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("b2b_start", req.busy, 1'b1);
         repeat (50) @(negedge clk);
         req.mem_addr = 5'($urandom); req.data_wr = 8'($urandom);
         repeat (100) @(negedge clk);
         if (k < 8) begin
            req.mem_addr = 5'(k + 1); req.data_wr = 8'((k + 1) * 17);
         end else begin
            req.en = 1'b0;
         end
         ref_mem[k] = 8'(k * 17);
         wait_idle();
         chk("b2b_ack_err", req.ack_err, 1'b0);
      end
      for (int i = 0; i < 32; i++) chk("b2b_mem_image", smem[i], ref_mem[i]);

      // Read back with repeated START
      do_txn(SLV_ADDR, 1'b0, 5'd3, 8'h00);

      // Asynchronous reset in the middle of the data byte of a write
      @(negedge clk);
      req.addr = SLV_ADDR; req.rw = 1'b1; req.mem_addr = 5'd9; req.data_wr = 8'h99; req.en = 1'b1;
      @(negedge clk);
      req.en = 1'b0;
      repeat (22 * BIT_CLKS) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_busy", req.busy, 1'b0);
      chk("midrst_ack_err", req.ack_err, 1'b0);
      chk("midrst_data_rd", req.data_rd, 8'h00);
      chk("midrst_sda", sda, 1'b1);
      chk("midrst_scl", scl, 1'b1);
      ref_rd = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // Aborted write must not have landed; next request completes normally
      do_txn(SLV_ADDR, 1'b0, 5'd9, 8'h00);

      // Randomised mix of writes, reads and wrong addresses
      for (int t = 0; t < 20; t++) begin
         logic [6:0] a;
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(2, 127)) : SLV_ADDR;
         do_txn(a, 1'($urandom), 5'($urandom), 8'($urandom));
      end

      for (int i = 0; i < 32; i++) chk("final_mem_image", smem[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
